// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU control decode, ALU, branch resolve, 2-entry skid buffer
module alu #(
    parameter int xlen = 64
) (
    input  logic [xlen-1:0] a_i,
    input  logic [xlen-1:0] b_i,
    input  logic [2:0]      ctrl_i,
    output logic [xlen-1:0] result_o
);
    always_comb begin
        result_o = a_i + b_i;
        case (ctrl_i)
            3'b000: result_o = a_i & b_i;
            3'b001: result_o = a_i | b_i;
            3'b010: result_o = a_i + b_i;
            3'b110: result_o = a_i - b_i;
            3'b111: result_o = {{(xlen-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: result_o = a_i + b_i;
        endcase
    end
endmodule

module ex_stage #(
    parameter int xlen = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [xlen-1:0] in_pc,
    input  logic [xlen-1:0] in_rs1_data,
    input  logic [xlen-1:0] in_rs2_data,
    input  logic [xlen-1:0] in_imm,
    input  logic            in_alu_src,
    input  logic [1:0]      in_alu_op,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    input  logic            in_is_branch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [xlen-1:0] out_result,
    output logic [xlen-1:0] out_rs2_data,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_branch_taken,
    output logic [xlen-1:0] out_branch_target,
    output logic            out_illegal
);
    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_SUB = 3'b110;
    localparam logic [2:0] CTRL_SLT = 3'b111;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    typedef struct packed {
        logic [xlen-1:0] result;
        logic [xlen-1:0] rs2_data;
        logic [xlen-1:0] target;
        logic [4:0]      rd;
        logic            reg_write;
        logic            taken;
        logic            illegal;
    } entry_t;

    state_t state_q, state_d;
    entry_t main_q, skid_q, new_entry;

    logic [2:0]      alu_ctrl;
    logic            illegal;
    logic [xlen-1:0] alu_b;
    logic [xlen-1:0] alu_result;
    logic            in_xfer, out_xfer;
    logic            load_main_new, load_main_skid, load_skid;

    always_comb begin
        alu_ctrl = CTRL_ADD;
        illegal  = 1'b0;
        case (in_alu_op)
            2'b00: alu_ctrl = CTRL_ADD;
            2'b01: alu_ctrl = CTRL_SUB;
            2'b10: begin
                case (in_funct3)
                    3'b000: alu_ctrl = (in_funct7b5 && !in_alu_src) ? CTRL_SUB : CTRL_ADD;
                    3'b111: alu_ctrl = CTRL_AND;
                    3'b110: alu_ctrl = CTRL_OR;
                    3'b010: alu_ctrl = CTRL_SLT;
                    default: begin
                        alu_ctrl = CTRL_ADD;
                        illegal  = 1'b1;
                    end
                endcase
            end
            default: begin
                alu_ctrl = CTRL_ADD;
                illegal  = 1'b1;
            end
        endcase
    end

    assign alu_b = in_alu_src ? in_imm : in_rs2_data;

    alu #(.xlen(xlen)) u_alu (
        .a_i      (in_rs1_data),
        .b_i      (alu_b),
        .ctrl_i   (alu_ctrl),
        .result_o (alu_result)
    );

    always_comb begin
        new_entry.result    = alu_result;
        new_entry.rs2_data  = in_rs2_data;
        new_entry.target    = in_pc + in_imm;
        new_entry.rd        = in_rd;
        new_entry.reg_write = in_reg_write;
        new_entry.taken     = in_is_branch && (alu_result == '0);
        new_entry.illegal   = illegal;
    end

    // in_ready depends only on state so out_ready never reaches upstream combinationally
    assign in_ready  = !rst && (state_q != S_TWO);
    assign out_valid = (state_q != S_EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_xfer) begin
                        state_d       = S_ONE;
                        load_main_new = 1'b1;
                    end
                end
                S_ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main_new = 1'b1;
                    end else if (in_xfer) begin
                        state_d   = S_TWO;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (out_xfer) begin
                        state_d        = S_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_new) begin
                main_q <= new_entry;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= new_entry;
            end
        end
    end

    assign out_result        = main_q.result;
    assign out_rs2_data      = main_q.rs2_data;
    assign out_rd            = main_q.rd;
    assign out_reg_write     = main_q.reg_write;
    assign out_branch_taken  = main_q.taken;
    assign out_branch_target = main_q.target;
    assign out_illegal       = main_q.illegal;
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the mini-cpu pipeline. Sits between the decode stage and the memory stage.
- Accepts decoded operands over a valid/ready handshake and derives the 3-bit ALU control.
- Drives the existing alu block.
- Registers the result, branch decision and branch target into a 2-entry skid buffer feeding the memory stage.

Parameters:
xlen, 64, datapath width in bits for operands, PC, immediate and result

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
flush  input  1  discard all held entries (branch redirect)
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry this cycle
in_pc  input  xlen  PC of instruction
in_rs1_data  input  xlen  operand a
in_rs2_data  input  xlen  register operand b / store data
in_imm  input  xlen  sign-extended immediate
in_alu_src  input  1  1: b=in_imm, 0: b=in_rs2_data
in_alu_op  input  2  00 mem-address, 01 branch, 10 arithmetic, 11 reserved
in_funct3  input  3  instruction funct3
in_funct7b5  input  1  instruction bit 30
in_rd  input  5  destination register
in_reg_write  input  1  writeback enable
in_is_branch  input  1  conditional branch (beq)
out_valid  output  1  output entry valid
out_ready  input  1  memory stage accepts entry
out_result  output  xlen  ALU result
out_rs2_data  output  xlen  store data passthrough
out_rd  output  5  destination register
out_reg_write  output  1  writeback enable
out_branch_taken  output  1  branch resolved taken
out_branch_target  output  xlen  in_pc + in_imm, modulo 2^xlen
out_illegal  output  1  unsupported op decoded

Behaviour:
- ALU control encoding: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (SLT result is 1 or 0, zero-extended).
- Decode from in_alu_op:
  - 00 -> ADD.
  - 01 -> SUB.
  - 10 -> by funct3:
    - 000 -> SUB if in_funct7b5=1 and in_alu_src=0, else ADD.
    - 111 -> AND.
    - 110 -> OR.
    - 010 -> SLT.
  - Any other funct3 under 10, and all of alu_op 11 -> ADD with illegal=1.
- ALU b operand: in_alu_src ? in_imm : in_rs2_data.
- out_branch_taken = in_is_branch AND (ALU result == 0). It is computed from the result bits and is 0 when in_is_branch=0.
- Branch target uses a separate adder. Carry-out is discarded (wrap-around).
- Latency: an entry accepted at edge N appears on outputs during cycle N+1 (one-cycle registered).
- Skid buffer states:
  - EMPTY: out_valid=0.
  - ONE: main register valid.
  - TWO: main plus skid register valid.
- in_ready = !rst AND state != TWO. It is a function of the state register only, with no combinational path from out_ready.
- Transfer rules: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
- Transitions:
  - EMPTY --in_xfer--> ONE.
  - ONE --in_xfer & !out_xfer--> TWO (new entry into skid).
  - ONE --out_xfer & !in_xfer--> EMPTY.
  - ONE --both--> ONE (main register reloaded with new entry).
  - TWO --out_xfer--> ONE (skid moves to main). No in_xfer is possible in TWO.
- Order is preserved. Outputs always present the oldest entry.
- Outputs hold stable while out_valid=1 and out_ready=0.
- flush: next state EMPTY regardless of in_valid and out_ready. An entry offered in the flush cycle is dropped. in_ready stays as computed from the current state.
- Reset: state EMPTY, out_valid=0.
  - All out_* data fields reset to 0: out_result, out_rs2_data, out_rd, out_reg_write, out_branch_taken, out_branch_target, out_illegal.
  - in_ready=0 while rst is high.
  - Reset mid-stream discards both entries.
- Priority: rst > flush > normal handshake.
- Data registers load only on transfer, so there is no toggling when idle.

Test Plan:
1. Single ADD: in_alu_op=10, funct3=000, funct7b5=0, alu_src=0, rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, out_result=12, out_illegal=0; stage returns to EMPTY after that cycle.
2. SUB/SLT/AND/OR: rs1=3, rs2=9 -> SUB gives 0xFFFF_FFFF_FFFF_FFFA; SLT gives 1; AND gives 1; OR gives 11. Each appears one cycle after acceptance.
3. Branch: alu_op=01, is_branch=1, rs1=rs2=0x40, pc=0x100, imm=-8 -> out_branch_taken=1, target=0xF8. With rs2=0x41 -> taken=0.
4. Backpressure: stream 4 entries with out_ready=0 -> in_ready drops after 2 accepted. Release out_ready -> outputs appear in order 1,2,3,4 with no loss or duplication, and outputs hold while stalled.
5. Flush in state TWO with in_valid=1 -> next cycle out_valid=0, state EMPTY; the offered entry never appears.
6. rst asserted with state TWO -> next cycle out_valid=0 and all out_* fields 0; in_ready=0 during rst and 1 the cycle after release. alu_op=11 -> out_illegal=1.
